corefifo_gray_ptr_sync_level: RTL
=================================

Name: corefifo_gray_ptr_sync_level

Overview:
Destination-domain pointer synchronizer for the async FIFO, and the successor to the plain N-stage bus synchronizer. It synchronizes a Gray-coded pointer from the far clock domain through a configurable number of flop stages and converts it to binary. It also detects illegal multi-bit Gray transitions and computes a registered fill level / availability count against the local binary pointer, with a full or empty flag. One instance sits on the write side (full/level) and one on the read side (empty/available).

Parameters:
NUM_STAGES, 2, synchronizer flop stages on gray_in; legal range 2..8.
ADDRWIDTH, 3, FIFO address width; pointers are ADDRWIDTH+1 bits (one wrap bit).
LEVEL_MODE, 0, 0 = write side (level = local - remote, at_limit = full); 1 = read side (level = remote - local, at_limit = empty).
ERR_STICKY, 1, 1 = gray_err holds until err_clr; 0 = gray_err is a one-cycle pulse.

Ports:
clk  in  1  destination-domain clock
arstn  in  1  asynchronous reset, active-low
srstn  in  1  synchronous reset, active-low
gray_in  in  ADDRWIDTH+1  Gray pointer from the far domain (asynchronous to clk)
local_bin  in  ADDRWIDTH+1  local binary pointer, synchronous to clk
err_clr  in  1  clears the sticky gray_err and lvl_err
sync_gray  out  ADDRWIDTH+1  output of the last synchronizer stage
sync_bin  out  ADDRWIDTH+1  registered Gray-to-binary conversion of sync_gray
upd  out  1  one-cycle pulse when sync_bin changes value
level  out  ADDRWIDTH+1  registered fill level (mode 0) or available count (mode 1); range 0..2^ADDRWIDTH
at_limit  out  1  full (mode 0: level == 2^ADDRWIDTH) or empty (mode 1: level == 0)
gray_err  out  1  Gray transition on sync_gray changed more than one bit
lvl_err  out  1  raw difference exceeded 2^ADDRWIDTH; level is saturated

Behaviour:
- Reset, arstn low (async) or srstn low (sync, at the next edge):
  - all stages, sync_gray, sync_bin, level, upd, gray_err and lvl_err go to 0.
  - at_limit goes to 0 in mode 0 and to 1 in mode 1 (empty).
  - srstn takes priority over all data and err_clr activity.
- Synchronizer: gray_in is sampled on edge 1 and shifted one stage per edge. sync_gray reflects gray_in after NUM_STAGES edges. The chain has no combinational path and no logic between stages.
- Conversion: bin[MSB] = g[MSB]; bin[i] = bin[i+1] XOR g[i]. The result is registered, so sync_bin is valid on edge NUM_STAGES+1.
- upd: high for the cycle in which sync_bin takes a new value that differs from the previous one.
- Gray check: compare stage NUM_STAGES-1 against stage NUM_STAGES. If more than one bit differs, gray_err is set on the same edge sync_bin updates.
  - sync_bin still takes the converted value; there is no hold-off.
  - ERR_STICKY=1: gray_err stays set until err_clr is sampled high. If set and clear occur in the same cycle, set wins.
- Level:
  - diff = (local_bin - sync_bin) in mode 0, or (sync_bin - local_bin) in mode 1, computed modulo 2^(ADDRWIDTH+1).
  - diff is registered on the edge after sync_bin, i.e. edge NUM_STAGES+2 from a gray_in change. Changes on local_bin appear on level 1 edge later.
  - If diff > 2^ADDRWIDTH: level saturates to 2^ADDRWIDTH and lvl_err is set, with the same sticky and clear rules as gray_err.
  - at_limit is registered in the same cycle as level and is derived from the saturated value.
- Wrap-around: pointer wrap is handled entirely by the modular subtraction. Both pointers wrapping with the wrap bit toggled gives the correct level.
- Simultaneous gray_in and local_bin changes: each change is applied through its own latency, with no special case.

Test Plan:
1. Reset: drive arstn low mid-stream in mode 0 and mode 1 -> all outputs 0 immediately; at_limit = 0 (mode 0) and 1 (mode 1). Release arstn and hold inputs at 0 -> outputs stay at reset values.
2. Latency (ADDRWIDTH=3, NUM_STAGES=2, mode 1, local_bin=0): gray_in 0000->0001 -> sync_gray=0001 at edge 2; sync_bin=0001 and upd=1 for 1 cycle at edge 3; level=1 and at_limit=0 at edge 4. Repeat with NUM_STAGES=4 -> every timing shifts by +2.
3. Full with wrap (mode 0): local_bin=0010, gray_in=1111 (bin 1010) -> level=8, at_limit=1, lvl_err=0. Then gray_in=1110 (bin 1011) -> level=7, at_limit=0.
4. Gray violation: gray_in 0000->0011 -> gray_err=1 at edge 3 and sync_bin=0010. It stays 1 through idle cycles and clears 1 cycle after err_clr. Asserting err_clr during a new violation -> gray_err stays 1.
5. Level saturation (mode 0): remote pointer 0, local_bin=1010 -> level=8, at_limit=1, lvl_err=1.
6. srstn mid-operation with level=5 and gray_err=1 -> all outputs cleared at the next edge; at_limit follows the reset value for the mode. After release, a fresh gray_in sequence reproduces the scenario 2 timing.

Source files
------------

// File: rtl/corefifo_gray_ptr_sync_level_if.sv
// Pointer-synchronizer bus: far-domain Gray pointer and local pointer in,
// synchronized pointer, level and error flags out.
interface corefifo_gray_ptr_sync_level_if #(
  parameter int ADDRWIDTH = 3
);
  logic [ADDRWIDTH:0] gray_in;
  logic [ADDRWIDTH:0] local_bin;
  logic               err_clr;
  logic [ADDRWIDTH:0] sync_gray;
  logic [ADDRWIDTH:0] sync_bin;
  logic               upd;
  logic [ADDRWIDTH:0] level;
  logic               at_limit;
  logic               gray_err;
  logic               lvl_err;

  modport master (
    output gray_in, local_bin, err_clr,
    input  sync_gray, sync_bin, upd, level, at_limit, gray_err, lvl_err
  );

  modport slave (
    input  gray_in, local_bin, err_clr,
    output sync_gray, sync_bin, upd, level, at_limit, gray_err, lvl_err
  );
endinterface

// File: rtl/corefifo_gray_ptr_sync_level.sv
// Destination-side Gray pointer synchronizer with Gray-to-binary conversion,
// illegal-transition detection and a registered, saturating fill/available level.
module corefifo_gray_ptr_sync_level #(
  parameter int NUM_STAGES = 2,
  parameter int ADDRWIDTH  = 3,
  parameter int LEVEL_MODE = 0,
  parameter int ERR_STICKY = 1
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           srstn,
  corefifo_gray_ptr_sync_level_if.slave  bus
);
  localparam int            W            = ADDRWIDTH + 1;
  localparam logic [W-1:0]  DEPTH        = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [W-1:0]  ONE          = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic [W-1:0]  ZERO         = {W{1'b0}};
  localparam logic          STICKY       = (ERR_STICKY != 0);
  localparam logic          AT_LIMIT_RST = (LEVEL_MODE != 0);

  logic [NUM_STAGES-1:0][W-1:0] stage_reg;
  logic [W-1:0] prev_gray_reg;
  logic [W-1:0] sync_bin_reg;
  logic         upd_reg;
  logic [W-1:0] level_reg;
  logic         at_limit_reg;
  logic         gray_err_reg;
  logic         lvl_err_reg;

  logic [W-1:0] sync_gray;
  logic [W-1:0] conv_bin;
  logic [W-1:0] gray_diff;
  logic         gray_set;
  logic [W-1:0] diff;
  logic         diff_sat;
  logic [W-1:0] level_next;
  logic         at_limit_next;
  logic         gray_err_next;
  logic         lvl_err_next;

  // Plain flop chain: nothing but wires between stages.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      stage_reg <= '0;
    end else if (!srstn) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= bus.gray_in;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign sync_gray = stage_reg[NUM_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_g2b
      assign conv_bin[gi] = ^sync_gray[W-1:gi];
    end
  endgenerate

  // x & (x-1) is non-zero exactly when more than one bit of x is set.
  assign gray_diff = sync_gray ^ prev_gray_reg;
  assign gray_set  = |(gray_diff & (gray_diff - ONE));

  assign diff          = (LEVEL_MODE == 0) ? (bus.local_bin - sync_bin_reg)
                                           : (sync_bin_reg - bus.local_bin);
  assign diff_sat      = (diff > DEPTH);
  assign level_next    = diff_sat ? DEPTH : diff;
  assign at_limit_next = (LEVEL_MODE == 0) ? (level_next == DEPTH) : (level_next == ZERO);

  // A new set always beats a clear arriving in the same cycle.
  assign gray_err_next = gray_set | (STICKY & gray_err_reg & ~bus.err_clr);
  assign lvl_err_next  = diff_sat | (STICKY & lvl_err_reg & ~bus.err_clr);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      prev_gray_reg <= '0;
      sync_bin_reg  <= '0;
      upd_reg       <= 1'b0;
      level_reg     <= '0;
      at_limit_reg  <= AT_LIMIT_RST;
      gray_err_reg  <= 1'b0;
      lvl_err_reg   <= 1'b0;
    end else if (!srstn) begin
      prev_gray_reg <= '0;
      sync_bin_reg  <= '0;
      upd_reg       <= 1'b0;
      level_reg     <= '0;
      at_limit_reg  <= AT_LIMIT_RST;
      gray_err_reg  <= 1'b0;
      lvl_err_reg   <= 1'b0;
    end else begin
      prev_gray_reg <= sync_gray;
      sync_bin_reg  <= conv_bin;
      upd_reg       <= (conv_bin != sync_bin_reg);
      level_reg     <= level_next;
      at_limit_reg  <= at_limit_next;
      gray_err_reg  <= gray_err_next;
      lvl_err_reg   <= lvl_err_next;
    end
  end

  assign bus.sync_gray = sync_gray;
  assign bus.sync_bin  = sync_bin_reg;
  assign bus.upd       = upd_reg;
  assign bus.level     = level_reg;
  assign bus.at_limit  = at_limit_reg;
  assign bus.gray_err  = gray_err_reg;
  assign bus.lvl_err   = lvl_err_reg;
endmodule
